// File: rtl/uart_tx_feeder_pkg.sv
// rtl/uart_tx_feeder_pkg.sv - shared FSM state, register offsets and bit positions for uart_tx_feeder
package uart_tx_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_SETUP  = 3'd1,
        ST_RD_ACCESS = 3'd2,
        ST_WR_SETUP  = 3'd3,
        ST_WR_ACCESS = 3'd4
    } state_t;

    // Slave register word offsets (PADDR[7:2])
    localparam logic [5:0] REG_DATA = 6'h00;
    localparam logic [5:0] REG_STAT = 6'h01;
    localparam logic [5:0] REG_CTRL = 6'h02;

    // STAT bit positions
    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 8;

    // CTRL bit positions
    localparam int CTRL_DRAIN = 0;
    localparam int CTRL_FLUSH = 1;
    localparam int CTRL_INTEN = 2;

endpackage

// File: rtl/uart_tx_feeder_fifo.sv
// rtl/uart_tx_feeder_fifo.sv - byte FIFO with flush, simultaneous push/pop and overflow detection
module uart_tx_feeder_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [7:0]               head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow_evt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // Accept/pop decisions and next pointer/count; flush wins over any push or pop in the same cycle
    always_comb begin
        do_pop       = pop & ~empty & ~flush;
        do_push      = push & (~full | do_pop) & ~flush;
        overflow_evt = push & full & ~do_pop & ~flush;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(do_push);
            rd_ptr_d = rd_ptr_q + AW'(do_pop);
            count_d  = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage write; the head is read before the edge, so a full-FIFO push with pop may reuse the slot
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - APB slave byte FIFO drained into a UART over an APB master port (optional FIFOINT via UART_TX_FEEDER_INT_EN)
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int         DEPTH          = 16,
    parameter logic [5:0] UART_STAT_ADDR = 6'h01,
    parameter logic [5:0] UART_TXD_ADDR  = 6'h02
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:2]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        M_PSEL,
    output logic        M_PENABLE,
    output logic        M_PWRITE,
    output logic [7:2]  M_PADDR,
    output logic [31:0] M_PWDATA,
    input  logic [31:0] M_PRDATA,
    input  logic        M_PREADY,
    output logic        FIFOINT
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t        state_q, state_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          flushed_q, flushed_d;
    logic          drain_q, drain_d;
    logic          ovf_q, ovf_d;
    logic          int_en;

    logic          wr_setup, wr_data, wr_stat, wr_ctrl;
    logic          flush;
    logic          fifo_pop;
    logic [7:0]    fifo_head;
    logic          fifo_full, fifo_empty, fifo_ovf;
    logic [CW-1:0] fifo_count;
    logic          unused_ok;

    assign PREADY    = 1'b1;
    assign PSLVERR   = 1'b0;
    assign unused_ok = ^{PWDATA[31:8], M_PRDATA[31:1]};

    assign wr_setup = PSEL & ~PENABLE & PWRITE;
    assign wr_data  = wr_setup & (PADDR == REG_DATA);
    assign wr_stat  = wr_setup & (PADDR == REG_STAT);
    assign wr_ctrl  = wr_setup & (PADDR == REG_CTRL);
    assign flush    = wr_ctrl & PWDATA[CTRL_FLUSH];

    uart_tx_feeder_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (PCLK),
        .rst_n        (PRESETn),
        .push         (wr_data),
        .push_data    (PWDATA[7:0]),
        .pop          (fifo_pop),
        .flush        (flush),
        .head_data    (fifo_head),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .count        (fifo_count),
        .overflow_evt (fifo_ovf)
    );

    // Control/status register updates; a new overflow beats a same-cycle clear
    always_comb begin
        drain_d = wr_ctrl ? PWDATA[CTRL_DRAIN] : drain_q;
        ovf_d   = ovf_q;
        if (fifo_ovf) begin
            ovf_d = 1'b1;
        end else if (wr_stat && PWDATA[STAT_OVF]) begin
            ovf_d = 1'b0;
        end
    end

`ifdef UART_TX_FEEDER_INT_EN
    logic inten_q, inten_d;
    logic fifoint_q, fifoint_d;

    assign int_en  = inten_q;
    assign FIFOINT = fifoint_q;

    // Interrupt enable and drained-level interrupt next values
    always_comb begin
        inten_d   = wr_ctrl ? PWDATA[CTRL_INTEN] : inten_q;
        fifoint_d = inten_q & fifo_empty & (state_q == ST_IDLE);
    end

    // Interrupt registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            inten_q   <= 1'b0;
            fifoint_q <= 1'b0;
        end else begin
            inten_q   <= inten_d;
            fifoint_q <= fifoint_d;
        end
    end
`else
    assign int_en  = 1'b0;
    assign FIFOINT = 1'b0;
`endif

    // Slave read mux, combinational so data is valid in the access phase
    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            case (PADDR)
                REG_STAT: begin
                    PRDATA[STAT_FULL]             = fifo_full;
                    PRDATA[STAT_EMPTY]            = fifo_empty;
                    PRDATA[STAT_OVF]              = ovf_q;
                    PRDATA[STAT_CNT_LSB +: 8]     = 8'(fifo_count);
                end
                REG_CTRL: begin
                    PRDATA[CTRL_DRAIN] = drain_q;
                    PRDATA[CTRL_INTEN] = int_en;
                end
                default: PRDATA = '0;
            endcase
        end
    end

    // Master FSM: poll UART status, write the latched head byte, pop unless a flush hit mid-transfer
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        flushed_d = (state_q == ST_IDLE) ? 1'b0 : (flushed_q | flush);
        fifo_pop  = 1'b0;
        M_PSEL    = 1'b0;
        M_PENABLE = 1'b0;
        M_PWRITE  = 1'b0;
        M_PADDR   = '0;
        M_PWDATA  = '0;
        case (state_q)
            ST_IDLE: begin
                if (drain_q && !fifo_empty && !flush) begin
                    state_d   = ST_RD_SETUP;
                    tx_data_d = fifo_head;
                end
            end
            ST_RD_SETUP: begin
                M_PSEL  = 1'b1;
                M_PADDR = UART_STAT_ADDR;
                state_d = ST_RD_ACCESS;
            end
            ST_RD_ACCESS: begin
                M_PSEL    = 1'b1;
                M_PENABLE = 1'b1;
                M_PADDR   = UART_STAT_ADDR;
                if (M_PREADY) begin
                    state_d = M_PRDATA[0] ? ST_IDLE : ST_WR_SETUP;
                end
            end
            ST_WR_SETUP: begin
                M_PSEL   = 1'b1;
                M_PWRITE = 1'b1;
                M_PADDR  = UART_TXD_ADDR;
                M_PWDATA = {24'b0, tx_data_q};
                state_d  = ST_WR_ACCESS;
            end
            ST_WR_ACCESS: begin
                M_PSEL    = 1'b1;
                M_PENABLE = 1'b1;
                M_PWRITE  = 1'b1;
                M_PADDR   = UART_TXD_ADDR;
                M_PWDATA  = {24'b0, tx_data_q};
                if (M_PREADY) begin
                    fifo_pop = ~flushed_q & ~flush;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, latched byte and control/status registers
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            tx_data_q <= '0;
            flushed_q <= 1'b0;
            drain_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            flushed_q <= flushed_d;
            drain_q   <= drain_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - scoreboard bench for uart_tx_feeder with a UART slave model
module tb_uart_tx_feeder;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:2]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic        M_PSEL, M_PENABLE, M_PWRITE;
    logic [7:2]  M_PADDR;
    logic [31:0] M_PWDATA, M_PRDATA;
    logic        M_PREADY;
    logic        FIFOINT;

    localparam logic [5:0] A_DATA = 6'h00;
    localparam logic [5:0] A_STAT = 6'h01;
    localparam logic [5:0] A_CTRL = 6'h02;

    always #5 PCLK = ~PCLK;

    uart_tx_feeder dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .M_PSEL    (M_PSEL),
        .M_PENABLE (M_PENABLE),
        .M_PWRITE  (M_PWRITE),
        .M_PADDR   (M_PADDR),
        .M_PWDATA  (M_PWDATA),
        .M_PRDATA  (M_PRDATA),
        .M_PREADY  (M_PREADY),
        .FIFOINT   (FIFOINT)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  exp_q[$];
    int          wr_wait = 0;
    int          full_polls = 0;
    int          stat_reads = 0;
    int          wr_count = 0;
    int          act_cnt = 0;
    int          acc_cnt = 0;
    int          push_cyc = 0;
    int          lat_meas = -1;
    bit          lat_arm = 0;
    logic [5:0]  setup_addr;
    logic [31:0] setup_wdata;
    logic        setup_write;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(posedge PCLK) cyc++;

    // UART slave model plus monitor: drives M_PREADY/M_PRDATA, checks stability and scoreboard on completion
    always @(negedge PCLK) begin
        if (M_PSEL) act_cnt++;
        if (M_PSEL && !M_PENABLE) begin
            acc_cnt     = 0;
            setup_addr  = M_PADDR;
            setup_wdata = M_PWDATA;
            setup_write = M_PWRITE;
            if (M_PWRITE && lat_arm) begin
                lat_meas = cyc - push_cyc;
                lat_arm  = 0;
            end
        end else if (M_PSEL && M_PENABLE) begin
            acc_cnt++;
            chk("m_stable", {M_PWRITE, M_PADDR, M_PWDATA[7:0]}, {setup_write, setup_addr, setup_wdata[7:0]});
        end
        M_PREADY = !(M_PSEL && M_PENABLE && M_PWRITE && acc_cnt <= wr_wait);
        M_PRDATA = {31'b0, full_polls != 0};
        if (M_PSEL && M_PENABLE && M_PREADY) begin
            if (!M_PWRITE) begin
                stat_reads++;
                chk("stat_rd_addr", M_PADDR, A_STAT);
                if (full_polls != 0) full_polls--;
            end else begin
                wr_count++;
                chk("txd_while_full", full_polls, 0);
                chk("txd_addr", M_PADDR, A_CTRL);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL txd_unexpected: got 0x%08h expected no write", M_PWDATA);
                end else begin
                    chk("txd_data", M_PWDATA, {24'b0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic apb_write(input logic [5:0] a, input logic [31:0] d);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1;
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input logic [5:0] a, output logic [31:0] d);
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1;
        #1 d = PRDATA;
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic push(input logic [7:0] b, input bit sent, input bit arm);
        if (sent) exp_q.push_back(b);
        if (arm) begin
            push_cyc = cyc;
            lat_arm  = 1;
        end
        apb_write(A_DATA, {24'b0, b});
    endtask

    task automatic chk_reg(input string name, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(a, d);
        chk(name, d, exp);
    endtask

    task automatic wait_drained(input int maxc);
        bit done = 0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge PCLK); #1;
            if (exp_q.size() == 0 && !M_PSEL) begin
                done = 1;
                break;
            end
        end
        chk("drain_done", done, 1);
    endtask

    initial begin
        int w0, r0, a0;
        bit found, busy_int;
        PRESETn = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
        M_PREADY = 1; M_PRDATA = '0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_master", {M_PSEL, M_PENABLE, M_PWRITE}, 0);
        chk("rst_master_bus", {M_PADDR, M_PWDATA[7:0]}, 0);
        chk("rst_fifoint", FIFOINT, 0);
        PRESETn = 1;
        @(posedge PCLK); #1;
        chk("pready_pslverr", {PREADY, PSLVERR}, 2'b10);
        chk_reg("rst_stat", A_STAT, 32'h0000_0002);
        chk_reg("rst_ctrl", A_CTRL, 32'h0);
        chk_reg("data_reads_0", A_DATA, 32'h0);

        // three bytes in order, first one timed from push to TXD setup
        apb_write(A_CTRL, 32'h1);
        push(8'h41, 1, 1);
        push(8'h42, 1, 0);
        push(8'h43, 1, 0);
        wait_drained(200);
        chk("writes_3", wr_count, 3);
        chk("latency", lat_meas, 4);
        chk_reg("stat_after_3", A_STAT, 32'h0000_0002);

        // UART busy for 5 polls
        full_polls = 5;
        r0 = stat_reads; w0 = wr_count;
        push(8'h55, 1, 0);
        wait_drained(300);
        chk("busy_polls", stat_reads - r0, 6);
        chk("busy_writes", wr_count - w0, 1);

        // wait states in WR_ACCESS
        wr_wait = 3;
        w0 = wr_count;
        push(8'h66, 1, 0);
        wait_drained(200);
        chk("wait_writes", wr_count - w0, 1);
        chk_reg("wait_stat", A_STAT, 32'h0000_0002);

        // fill and overflow with drain disabled
        apb_write(A_CTRL, 32'h0);
        a0 = act_cnt;
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i), 0, 0);
        chk_reg("stat_full16", A_STAT, 32'h0000_1001);
        push(8'h90, 0, 0);
        chk_reg("stat_ovf", A_STAT, 32'h0000_1005);
        apb_write(A_STAT, 32'h4);
        chk_reg("stat_ovf_clr", A_STAT, 32'h0000_1001);
        apb_write(A_CTRL, 32'h2);
        chk_reg("stat_flushed", A_STAT, 32'h0000_0002);
        chk_reg("ctrl_flush_rd0", A_CTRL, 32'h0);
        chk("no_drain_activity", act_cnt - a0, 0);

        // flush during WR_ACCESS with 5 entries
        for (int i = 0; i < 5; i++) push(8'h71 + 8'(i), i == 0, 0);
        w0 = wr_count;
        apb_write(A_CTRL, 32'h1);
        found = 0;
        for (int i = 0; i < 100; i++) begin
            if (M_PSEL && M_PENABLE && M_PWRITE) begin
                found = 1;
                break;
            end
            @(posedge PCLK); #1;
        end
        chk("reach_wr_access", found, 1);
        apb_write(A_CTRL, 32'h3);
        chk_reg("flush_count0", A_STAT, 32'h0000_0002);
        wait_drained(100);
        chk("flush_writes", wr_count - w0, 1);
        a0 = act_cnt;
        repeat (50) @(posedge PCLK);
        #1;
        chk("flush_quiet", act_cnt - a0, 0);
        wr_wait = 0;

`ifdef UART_TX_FEEDER_INT_EN
        apb_write(A_CTRL, 32'h5);
        repeat (2) @(posedge PCLK);
        #1;
        chk("int_idle_empty", FIFOINT, 1);
        chk_reg("ctrl_rd5", A_CTRL, 32'h5);
        w0 = wr_count;
        push(8'h5A, 1, 0);
        found = 0; busy_int = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge PCLK); #1;
            if (M_PSEL) busy_int |= FIFOINT;
            if (wr_count == w0 + 1) begin
                found = 1;
                break;
            end
        end
        chk("int_write_done", found, 1);
        chk("int_busy_low", busy_int, 0);
        chk("int_first_idle", FIFOINT, 0);
        @(posedge PCLK); #1;
        chk("int_rise", FIFOINT, 1);
`else
        apb_write(A_CTRL, 32'h5);
        chk_reg("ctrl_rd_noint", A_CTRL, 32'h1);
        push(8'h5A, 1, 0);
        wait_drained(100);
        repeat (2) @(posedge PCLK);
        #1;
        chk("fifoint_tied0", FIFOINT, 0);
`endif
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 4..64).
REQ-002 SHALL have parameter UART_STAT_ADDR, default 6'h01, UART status word address (PADDR[7:2]).
REQ-003 SHALL have parameter UART_TXD_ADDR, default 6'h02, UART TX data word address (PADDR[7:2]).
REQ-004 SHALL have port PCLK  in  1  clock; one clock, all logic on rising edge.
REQ-005 SHALL have port PRESETn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports PSEL/PENABLE/PWRITE  in  1 each  APB slave controls.
REQ-007 SHALL have ports PADDR  in  [7:2] and PWDATA  in  32  slave address/write data.
REQ-008 SHALL have ports PRDATA  out  32, PREADY  out  1 (tied 1), PSLVERR  out  1 (tied 0).
REQ-009 SHALL have ports M_PSEL/M_PENABLE/M_PWRITE  out  1 each  APB master controls to the UART.
REQ-010 SHALL have ports M_PADDR  out  [7:2], M_PWDATA  out  32, M_PRDATA  in  32, M_PREADY  in  1.
REQ-011 SHALL have port FIFOINT  out  1  level interrupt, FIFO drained.

Function
REQ-012 Slave map: 0x00 DATA (W: push PWDATA[7:0]; R: 0); 0x04 STAT; 0x08 CTRL; others read 0, writes ignored.
REQ-013 STAT: [0] full, [1] empty, [2] overflow (write 1 clears), [15:8] occupancy count; other bits 0.
REQ-014 CTRL: [0] drain enable, [1] flush (write-only, self-clearing, reads 0), [2] interrupt enable.
REQ-015 Slave writes take effect in the setup cycle (PSEL & ~PENABLE & PWRITE); reads are combinational, valid in the access phase.
REQ-016 Push when full: data dropped, overflow set, count unchanged.
REQ-017 Master FSM states: IDLE, RD_SETUP, RD_ACCESS, WR_SETUP, WR_ACCESS.
REQ-018 IDLE -> RD_SETUP when CTRL[0] & ~empty; otherwise remain in IDLE.
REQ-019 RD_SETUP: M_PSEL=1, M_PENABLE=0, M_PWRITE=0, M_PADDR=UART_STAT_ADDR; next state RD_ACCESS.
REQ-020 RD_ACCESS: M_PENABLE=1; hold until M_PREADY. Then M_PRDATA[0]=1 (UART buffer full) -> IDLE (retry); M_PRDATA[0]=0 -> WR_SETUP.
REQ-021 WR_SETUP: M_PWRITE=1, M_PADDR=UART_TXD_ADDR, M_PWDATA={24'b0, head byte}; next state WR_ACCESS.
REQ-022 WR_ACCESS: M_PENABLE=1; on M_PREADY, pop head, go to IDLE.
REQ-023 Outside RD_SETUP through WR_ACCESS: all M_* outputs 0.
REQ-024 Head byte and master address/data SHALL be stable from setup through completion of access.
REQ-025 Simultaneous push and pop: count unchanged; a push when full coinciding with a pop SHALL be accepted.
REQ-026 Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits wide.
REQ-027 Flush: empty FIFO the next cycle. A flush during an in-progress master transfer SHALL let the transfer complete with latched data and no pop; FSM then returns to IDLE.
REQ-028 Clearing CTRL[0] mid-transfer SHALL not abort the transfer; it only blocks IDLE -> RD_SETUP.
REQ-029 Minimum latency, push into empty FIFO to UART TXD write setup: 4 cycles with zero-wait M_PREADY.

Reset
REQ-030 On PRESETn low: FIFO empty, pointers 0, overflow 0, CTRL 0, FSM IDLE, M_* 0, FIFOINT 0.
REQ-031 Reset mid-transfer SHALL abandon the transfer immediately; the popped byte is not guaranteed sent.

Configuration
REQ-032 Macro UART_TX_FEEDER_INT_EN defined: FIFOINT is a registered output = CTRL[2] & empty & FSM in IDLE.
REQ-033 Macro UART_TX_FEEDER_INT_EN undefined: FIFOINT tied 0, CTRL[2] not stored, reads 0.

Structure
REQ-034 A shared package SHALL hold the FSM state enum, slave register offsets, and STAT/CTRL bit-position constants.
REQ-035 The FIFO storage, pointers and count SHALL be one sub-module, uart_tx_feeder_fifo; FSM and APB logic stay in the top level.

Verification
REQ-036 Enable, push 0x41,0x42,0x43, UART never full -> three UART TXD writes, in order, data 0x41,0x42,0x43; STAT.empty=1 afterwards.
REQ-037 UART STAT bit0=1 for 5 polls then 0 -> repeated STAT reads, no TXD write until bit0=0; then exactly one write.
REQ-038 Push 17 bytes with CTRL[0]=0, DEPTH=16 -> STAT = full 1, overflow 1, count 16; write STAT 0x4 -> overflow 0.
REQ-039 M_PREADY held low 3 cycles in WR_ACCESS -> M_PWDATA and M_PADDR stable throughout; single pop.
REQ-040 Flush asserted during WR_ACCESS with 5 entries -> in-flight byte written once; count=0 next cycle; no further master activity.
REQ-041 With UART_TX_FEEDER_INT_EN and CTRL=0x5, push 1 byte -> FIFOINT 0 while busy, rises 1 cycle after return to IDLE with empty FIFO.
